// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one multi-cycle signed 21-bit divider among four requesters.
// Optional DIV_SCHED_ZERO_GUARD_EN: zero divisors are answered without occupying the divider.
module divider_scheduler #(
    parameter int LATENCY = 44
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [83:0] dividend_in,
    input  logic [83:0] divisor_in,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [20:0] quotient_out,
    output logic        dz_flag,
    output logic        busy,
    output logic        div_open,
    output logic [20:0] div_dividend,
    output logic [20:0] div_divisor,
    input  logic [20:0] div_quotient
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  winner_reg, winner_next;
    logic [1:0]  last_reg, last_next;
    logic [5:0]  count_reg, count_next;
    logic [20:0] op_dividend_reg, op_dividend_next;
    logic [20:0] op_divisor_reg, op_divisor_next;
    logic [3:0]  grant_reg, grant_next;
    logic [3:0]  done_reg, done_next;
    logic [20:0] quotient_reg, quotient_next;
    logic        dz_reg, dz_next;
`ifdef DIV_SCHED_ZERO_GUARD_EN
    logic        zpend_reg, zpend_next;
`endif

    logic [20:0] dividend_arr [4];
    logic [20:0] divisor_arr [4];
    logic [1:0]  arb_idx;
    logic [1:0]  arb_probe;
    logic        arb_found;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign dividend_arr[gi] = dividend_in[21*gi +: 21];
            assign divisor_arr[gi]  = divisor_in[21*gi +: 21];
        end
    endgenerate

    // Search starts one past the last-served requester so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_reg;
        arb_probe = last_reg;
        for (int i = 1; i <= 4; i++) begin
            arb_probe = last_reg + 2'(i);
            if (!arb_found && req[arb_probe]) begin
                arb_found = 1'b1;
                arb_idx   = arb_probe;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        winner_next      = winner_reg;
        last_next        = last_reg;
        count_next       = count_reg;
        op_dividend_next = op_dividend_reg;
        op_divisor_next  = op_divisor_reg;
        grant_next       = 4'b0000;
        done_next        = 4'b0000;
        quotient_next    = quotient_reg;
        dz_next          = 1'b0;
`ifdef DIV_SCHED_ZERO_GUARD_EN
        zpend_next       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
`ifdef DIV_SCHED_ZERO_GUARD_EN
                if (zpend_reg) begin
                    // Saturated answer for x/0, delivered the cycle after grant.
                    done_next     = 4'(1) << winner_reg;
                    quotient_next = op_dividend_reg[20] ? 21'h100000 : 21'h0FFFFF;
                    dz_next       = 1'b1;
                    last_next     = winner_reg;
                end else
`endif
                if (arb_found) begin
                    winner_next      = arb_idx;
                    op_dividend_next = dividend_arr[arb_idx];
                    op_divisor_next  = divisor_arr[arb_idx];
                    grant_next       = 4'(1) << arb_idx;
                    count_next       = 6'd0;
`ifdef DIV_SCHED_ZERO_GUARD_EN
                    if (divisor_arr[arb_idx] == 21'd0) begin
                        zpend_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                count_next = count_reg + 6'd1;
                if (count_reg == 6'(LATENCY - 1)) begin
                    quotient_next = div_quotient;
                    done_next     = 4'(1) << winner_reg;
                    dz_next       = (op_divisor_reg == 21'd0);
                    last_next     = winner_reg;
                    count_next    = 6'd0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            winner_reg      <= 2'd0;
            last_reg        <= 2'd3;
            count_reg       <= 6'd0;
            op_dividend_reg <= 21'd0;
            op_divisor_reg  <= 21'd0;
            grant_reg       <= 4'b0000;
            done_reg        <= 4'b0000;
            quotient_reg    <= 21'd0;
            dz_reg          <= 1'b0;
`ifdef DIV_SCHED_ZERO_GUARD_EN
            zpend_reg       <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            winner_reg      <= winner_next;
            last_reg        <= last_next;
            count_reg       <= count_next;
            op_dividend_reg <= op_dividend_next;
            op_divisor_reg  <= op_divisor_next;
            grant_reg       <= grant_next;
            done_reg        <= done_next;
            quotient_reg    <= quotient_next;
            dz_reg          <= dz_next;
`ifdef DIV_SCHED_ZERO_GUARD_EN
            zpend_reg       <= zpend_next;
`endif
        end
    end

    // Idle operands are 1/1 so the divider never evaluates 0/0.
    assign busy         = (state_reg == RUN);
    assign div_open     = busy;
    assign div_dividend = busy ? op_dividend_reg : 21'd1;
    assign div_divisor  = busy ? op_divisor_reg : 21'd1;
    assign grant        = grant_reg;
    assign done         = done_reg;
    assign quotient_out = quotient_reg;
    assign dz_flag      = dz_reg;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler: one LATENCY=44 instance and one LATENCY=2 instance,
// each fed by a behavioural divider whose quotient is only valid after the full latency.
module tb_divider_scheduler;

    localparam int LAT_A = 44;
    localparam int LAT_B = 2;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  req_a, req_b;
    logic [83:0] dividend_in, divisor_in;

    logic [3:0]  grant_a, done_a, grant_b, done_b;
    logic [20:0] quotient_out_a, quotient_out_b;
    logic        dz_flag_a, dz_flag_b, busy_a, busy_b, div_open_a, div_open_b;
    logic [20:0] div_dividend_a, div_divisor_a, div_dividend_b, div_divisor_b;
    logic [20:0] div_quotient_a, div_quotient_b;
    int          open_cnt_a, open_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    divider_scheduler #(.LATENCY(LAT_A)) dut_a (
        .CLK(CLK), .rst(rst), .req(req_a),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .grant(grant_a), .done(done_a), .quotient_out(quotient_out_a),
        .dz_flag(dz_flag_a), .busy(busy_a), .div_open(div_open_a),
        .div_dividend(div_dividend_a), .div_divisor(div_divisor_a),
        .div_quotient(div_quotient_a)
    );

    divider_scheduler #(.LATENCY(LAT_B)) dut_b (
        .CLK(CLK), .rst(rst), .req(req_b),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .grant(grant_b), .done(done_b), .quotient_out(quotient_out_b),
        .dz_flag(dz_flag_b), .busy(busy_b), .div_open(div_open_b),
        .div_dividend(div_dividend_b), .div_divisor(div_divisor_b),
        .div_quotient(div_quotient_b)
    );

    function automatic logic [20:0] ref_div(input logic [20:0] a, input logic [20:0] b);
        if (b == 21'd0) return 21'h155555;
        return 21'($signed(a) / $signed(b));
    endfunction

    // Divider models: quotient is garbage until open has been held for the full latency.
    always @(posedge CLK or posedge rst) begin
        if (rst) open_cnt_a <= 0;
        else open_cnt_a <= div_open_a ? open_cnt_a + 1 : 0;
    end
    always @(posedge CLK or posedge rst) begin
        if (rst) open_cnt_b <= 0;
        else open_cnt_b <= div_open_b ? open_cnt_b + 1 : 0;
    end
    assign div_quotient_a = (div_open_a && open_cnt_a >= LAT_A - 1) ?
                            ref_div(div_dividend_a, div_divisor_a) : 21'h0AAAAA;
    assign div_quotient_b = (div_open_b && open_cnt_b >= LAT_B - 1) ?
                            ref_div(div_dividend_b, div_divisor_b) : 21'h0AAAAA;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    task automatic set_ops(input int k, input logic [20:0] dvd, input logic [20:0] dvs);
        dividend_in[21*k +: 21] = dvd;
        divisor_in[21*k +: 21]  = dvs;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
    endtask

    // Called at a negedge; waits for grant, then follows the operation to its done pulse.
    task automatic run_op(input string tag, input int who, input logic [20:0] exp_q,
                          input logic exp_dz, input bit drop, input int exp_lat,
                          input int exp_open, output int wait_cyc);
        int n;
        int open_cyc;
        wait_cyc = 0;
        while (grant_a == 4'b0000 && wait_cyc < 200) begin
            @(negedge CLK);
            wait_cyc++;
        end
        check_val({tag, "_grant"}, 32'(grant_a), 32'(1) << who);
        if (grant_a == 4'b0000) return;
        if (exp_open > 0) begin
            check_val({tag, "_opnd"}, 32'(div_dividend_a), 32'(dividend_in[21*who +: 21]));
        end
        if (drop) req_a[who] = 1'b0;
        n = 0;
        open_cyc = 0;
        while (done_a == 4'b0000 && n < 200) begin
            if (div_open_a) open_cyc++;
            @(negedge CLK);
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_open"}, 32'(open_cyc), 32'(exp_open));
        check_val({tag, "_done"}, 32'(done_a), 32'(1) << who);
        check_val({tag, "_gnt0"}, 32'(grant_a), 32'd0);
        check_val({tag, "_q"}, 32'(quotient_out_a), 32'(exp_q));
        check_val({tag, "_dz"}, 32'(dz_flag_a), 32'(exp_dz));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [20:0] rr_q [4];
        rst = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        dividend_in = '0;
        divisor_in = '0;
        repeat (2) @(negedge CLK);

        check_val("rst_grant", 32'(grant_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_open", 32'(div_open_a), 32'd0);
        check_val("rst_q", 32'(quotient_out_a), 32'd0);
        check_val("rst_dz", 32'(dz_flag_a), 32'd0);
        check_val("rst_dvd", 32'(div_dividend_a), 32'd1);
        check_val("rst_dvs", 32'(div_divisor_a), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("idle_busy", 32'(busy_a), 32'd0);
        check_val("idle_grant", 32'(grant_a), 32'd0);

        // Single operation 1000/10
        set_ops(0, 21'd1000, 21'd10);
        req_a = 4'b0001;
        run_op("single", 0, 21'd100, 1'b0, 1'b1, LAT_A, LAT_A, w);
        check_val("single_wait", 32'(w), 32'd1);

        // Round robin with all four held
        do_reset();
        set_ops(0, 21'd1000, 21'd10);
        set_ops(1, 21'(-600), 21'd20);
        set_ops(2, 21'd7, 21'd2);
        set_ops(3, 21'd50, 21'(-7));
        rr_q[0] = 21'd100;
        rr_q[1] = 21'(-30);
        rr_q[2] = 21'd3;
        rr_q[3] = 21'(-7);
        req_a = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("rr%0d", i), i % 4, rr_q[i % 4], 1'b0, 1'b0, LAT_A, LAT_A, w);
            if (i > 0) check_val($sformatf("rr%0d_b2b", i), 32'(w), 32'd1);
        end
        req_a = 4'b0000;
        @(negedge CLK);

        // Fairness: serve 2, then 0101 must give 0 before 2
        do_reset();
        set_ops(2, 21'd7, 21'd2);
        req_a = 4'b0100;
        run_op("fair_pre", 2, 21'd3, 1'b0, 1'b1, LAT_A, LAT_A, w);
        set_ops(0, 21'(-600), 21'd20);
        req_a = 4'b0101;
        run_op("fair_0", 0, 21'(-30), 1'b0, 1'b1, LAT_A, LAT_A, w);
        run_op("fair_2", 2, 21'd3, 1'b0, 1'b1, LAT_A, LAT_A, w);
        check_val("fair_2_b2b", 32'(w), 32'd1);

        // Zero divisor
        set_ops(3, 21'(-5), 21'd0);
        req_a = 4'b1000;
`ifdef DIV_SCHED_ZERO_GUARD_EN
        run_op("zdiv", 3, 21'h100000, 1'b1, 1'b1, 1, 0, w);
`else
        run_op("zdiv", 3, 21'h155555, 1'b1, 1'b1, LAT_A, LAT_A, w);
`endif

        // Reset in the middle of requester 1's operation
        set_ops(1, 21'd300, 21'd3);
        req_a = 4'b0010;
        n = 0;
        while (grant_a == 4'b0000 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_val("mid_grant", 32'(grant_a), 32'b0010);
        repeat (20) @(negedge CLK);
        check_val("mid_nodone", 32'(done_a), 32'd0);
        req_a = 4'b0110;
        #1 rst = 1'b1;
        #1;
        check_val("mid_busy", 32'(busy_a), 32'd0);
        check_val("mid_open", 32'(div_open_a), 32'd0);
        check_val("mid_q", 32'(quotient_out_a), 32'd0);
        check_val("mid_dvd", 32'(div_dividend_a), 32'd1);
        @(negedge CLK);
        rst = 1'b0;
        run_op("after_rst", 1, 21'd100, 1'b0, 1'b1, LAT_A, LAT_A, w);
        check_val("after_rst_wait", 32'(w), 32'd1);
        req_a = 4'b0000;
        @(negedge CLK);

        // LATENCY=2 instance: 7/2
        set_ops(2, 21'd7, 21'd2);
        req_b = 4'b0100;
        n = 0;
        while (grant_b == 4'b0000 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_val("lat2_grant", 32'(grant_b), 32'b0100);
        req_b = 4'b0000;
        n = 0;
        while (done_b == 4'b0000 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_val("lat2_lat", 32'(n), 32'd2);
        check_val("lat2_done", 32'(done_b), 32'b0100);
        check_val("lat2_q", 32'(quotient_out_b), 32'd3);
        check_val("lat2_dz", 32'(dz_flag_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
